rbm_batch_controller: RTL
=========================

RBM_BATCH_CONTROLLER -- requirements
Module: rbm_batch_controller

Interface
REQ-001 SHALL provide parameters:
- BITLENGTH, 12, width of each signed core output score.
- OUTPUT_DIM, 10, number of class scores per image.
- IMAGE_NUM, 16, images per batch (at least 1).
- ADDR_W, 4, image address width; 2^ADDR_W >= IMAGE_NUM.
- LABEL_W, 4, label width; 2^LABEL_W > OUTPUT_DIM.
- CNT_W, 8, counter width.
- TIMEOUT, 4096, maximum cycles from data_valid rising to core_finish.
- CORE_RST_CYCLES, 3, core reset pulse length.

REQ-002 SHALL have the following ports (clock and reset first):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a batch.
- img_addr  out  ADDR_W  index of the current image in the external image/label store.
- label_in  in  LABEL_W  expected label for img_addr; valid from the cycle after img_addr changes.
- core_reset  out  1  reset to the RBM core.
- core_data_valid  out  1  data_valid to the RBM core.
- core_finish  in  1  finish from the RBM core.
- core_out  in  OUTPUT_DIM*BITLENGTH  packed core scores; element i occupies bits [i*BITLENGTH +: BITLENGTH].
- pred_label  out  LABEL_W  argmax of the last scored image.
- pred_valid  out  1  one-cycle strobe when pred_label updates.
- img_count  out  CNT_W  number of images completed.
- correct_count  out  CNT_W  number of correct predictions.
- timeout_err  out  1  sticky flag: at least one image timed out.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.

Function
REQ-003 SHALL implement the states IDLE, CORE_RST, RUN, SCORE, NEXT and DONE.

REQ-004 From IDLE or DONE, start SHALL perform the following on the next edge:
- clear img_addr, img_count, correct_count and timeout_err;
- go to CORE_RST.
start SHALL be ignored in all other states.

REQ-005 CORE_RST SHALL hold core_reset=1 and core_data_valid=0 for exactly CORE_RST_CYCLES cycles, then go to RUN.

REQ-006 RUN SHALL hold core_data_valid=1 and run a watchdog counter that starts at 0.

REQ-007 In RUN, the first core_finish rising edge SHALL trigger the following on the next edge:
- capture core_out into an internal register;
- go to SCORE.
A core_finish level held high without a rising edge SHALL NOT retrigger.

REQ-008 If the watchdog reaches TIMEOUT-1 without core_finish, the block SHALL perform the following on the next edge:
- set timeout_err;
- set pred_label to all ones and pulse pred_valid;
- leave correct_count unchanged;
- go to NEXT.
If core_finish and the timeout occur in the same cycle, core_finish SHALL win.

REQ-009 SCORE SHALL compute argmax sequentially, one element per cycle, as a signed two's-complement comparison over elements 0..OUTPUT_DIM-1.
- Ties SHALL resolve to the lowest index.
- SCORE SHALL last exactly OUTPUT_DIM cycles.
- pred_valid SHALL pulse on the final cycle, with pred_label equal to the winning index.
- The state SHALL then go to NEXT.

REQ-010 NEXT SHALL take one cycle and SHALL:
- increment img_count, saturating at 2^CNT_W-1;
- if img_count has reached IMAGE_NUM, go to DONE;
- otherwise increment img_addr and go to CORE_RST.

REQ-011 core_data_valid SHALL be 0 in every state other than RUN; core_reset SHALL be 0 in every state other than CORE_RST.

REQ-012 Latency per non-timed-out image SHALL be CORE_RST_CYCLES + (cycles in RUN) + 1 capture cycle + OUTPUT_DIM + 1 cycles.

Reset
REQ-013 Asserting reset SHALL force the following, from any state and including mid-batch:
- state=IDLE;
- img_addr, img_count, correct_count and pred_label = 0;
- pred_valid, timeout_err, busy, done and core_data_valid = 0;
- core_reset=1 while reset is high, then 0 in IDLE.

REQ-014 Reset mid-RUN SHALL discard any partial argmax or captured scores; the next start SHALL begin again from image 0.

Configuration
REQ-015 With macro RBM_ACCURACY_EN defined, when pred_valid pulses and pred_label equals label_in, correct_count SHALL increment, saturating.
- A timed-out image SHALL never count as correct.

REQ-016 With RBM_ACCURACY_EN undefined:
- correct_count SHALL be constant 0;
- label_in SHALL be unused;
- no comparator or counter logic SHALL be synthesised.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Single image: OUTPUT_DIM=10, scores {5,-3,100,7,...,0}, label_in=2, with RBM_ACCURACY_EN -> pred_label=2, correct_count=1, img_count=1, done=1.
- Tie and negatives: scores all -50 except elements 4 and 7 = 20 -> pred_label=4; all scores = -2048 (0x800) -> pred_label=0.
- Timeout: TIMEOUT=64, core_finish never asserted -> at cycle 64 of RUN, timeout_err=1, pred_label=4'hF, correct_count unchanged, batch continues to next img_addr.
- Batch of IMAGE_NUM=4 with labels matching on images 0, 1 and 3 -> img_count=4, correct_count=3, img_addr sequence 0..3, and core_reset high exactly CORE_RST_CYCLES cycles before each RUN.
- Reset asserted 10 cycles into RUN of image 2 -> all outputs at reset values; start then replays from img_addr=0.
- Build without RBM_ACCURACY_EN, same 4-image batch -> correct_count stays 0; pred_label sequence identical to the enabled build.

Source files
------------

// File: rtl/rbm_batch_controller.sv
// rbm_batch_controller: runs an RBM core over a batch of images and takes an argmax of each image's scores.
// Optional feature: define RBM_ACCURACY_EN to count predictions that match label_in.
module rbm_batch_controller #(
    parameter int BITLENGTH       = 12,
    parameter int OUTPUT_DIM      = 10,
    parameter int IMAGE_NUM       = 16,
    parameter int ADDR_W          = 4,
    parameter int LABEL_W         = 4,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT         = 4096,
    parameter int CORE_RST_CYCLES = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    output logic [ADDR_W-1:0]               img_addr,
    input  logic [LABEL_W-1:0]              label_in,
    output logic                            core_reset,
    output logic                            core_data_valid,
    input  logic                            core_finish,
    input  logic [OUTPUT_DIM*BITLENGTH-1:0] core_out,
    output logic [LABEL_W-1:0]              pred_label,
    output logic                            pred_valid,
    output logic [CNT_W-1:0]                img_count,
    output logic [CNT_W-1:0]                correct_count,
    output logic                            timeout_err,
    output logic                            busy,
    output logic                            done
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(CORE_RST_CYCLES + 1);
    localparam int IX_W = $clog2(OUTPUT_DIM + 1);

    typedef enum logic [2:0] {IDLE, CORE_RST, RUN, SCORE, NEXT, DONE} state_t;

    state_t                          state;
    logic [RC_W-1:0]                 rcnt;
    logic [WD_W-1:0]                 wdog;
    logic [IX_W-1:0]                 sidx;
    logic [OUTPUT_DIM*BITLENGTH-1:0] scores;
    logic signed [BITLENGTH-1:0]     best;
    logic signed [BITLENGTH-1:0]     cur;
    logic [LABEL_W-1:0]              best_idx;
    logic [LABEL_W-1:0]              win_idx;
    logic                            finish_q;
    logic                            take;

    // Element 0 is seeded at capture, so SCORE walks 1..OUTPUT_DIM-1 and spends its last cycle presenting the result.
    assign cur     = scores[int'(sidx)*BITLENGTH +: BITLENGTH];
    assign take    = cur > best;
    assign win_idx = take ? LABEL_W'(sidx) : best_idx;
    assign busy    = !(state == IDLE || state == DONE);
    assign done    = state == DONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            img_addr        <= '0;
            img_count       <= '0;
            pred_label      <= '0;
            pred_valid      <= 1'b0;
            timeout_err     <= 1'b0;
            core_reset      <= 1'b1;
            core_data_valid <= 1'b0;
            rcnt            <= '0;
            wdog            <= '0;
            sidx            <= '0;
            scores          <= '0;
            best            <= '0;
            best_idx        <= '0;
            finish_q        <= 1'b0;
        end else begin
            finish_q   <= core_finish;
            pred_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    core_reset <= 1'b0;
                    if (start) begin
                        img_addr    <= '0;
                        img_count   <= '0;
                        timeout_err <= 1'b0;
                        rcnt        <= '0;
                        core_reset  <= 1'b1;
                        state       <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    if (rcnt == RC_W'(CORE_RST_CYCLES - 1)) begin
                        core_reset      <= 1'b0;
                        core_data_valid <= 1'b1;
                        wdog            <= '0;
                        state           <= RUN;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                RUN: begin
                    // A finish edge beats a watchdog expiry in the same cycle.
                    if (core_finish && !finish_q) begin
                        scores          <= core_out;
                        best            <= core_out[BITLENGTH-1:0];
                        best_idx        <= '0;
                        sidx            <= IX_W'(1);
                        core_data_valid <= 1'b0;
                        state           <= SCORE;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        timeout_err     <= 1'b1;
                        pred_label      <= '1;
                        pred_valid      <= 1'b1;
                        core_data_valid <= 1'b0;
                        state           <= NEXT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                SCORE: begin
                    if (pred_valid) begin
                        state <= NEXT;
                    end else begin
                        best     <= take ? cur : best;
                        best_idx <= win_idx;
                        sidx     <= sidx + 1'b1;
                        if (sidx == IX_W'(OUTPUT_DIM - 1)) begin
                            pred_label <= win_idx;
                            pred_valid <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (img_count != '1) img_count <= img_count + 1'b1;
                    if (img_count >= CNT_W'(IMAGE_NUM - 1)) begin
                        state <= DONE;
                    end else begin
                        img_addr   <= img_addr + 1'b1;
                        rcnt       <= '0;
                        core_reset <= 1'b1;
                        state      <= CORE_RST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RBM_ACCURACY_EN
    // Only the SCORE-side strobe can count; a timeout strobe fires from NEXT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            correct_count <= '0;
        else if (start && (state == IDLE || state == DONE))
            correct_count <= '0;
        else if (state == SCORE && pred_valid && pred_label == label_in && correct_count != '1)
            correct_count <= correct_count + 1'b1;
    end
`else
    logic unused_label;
    assign unused_label  = ^label_in;
    assign correct_count = '0;
`endif

endmodule
